// File: rtl/uart_pkg.sv
// uart_pkg: shared UART frame constants and receiver state encoding
package uart_pkg;
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_START = 2'b01;
  localparam logic [1:0] ST_DATA  = 2'b10;
  localparam logic [1:0] ST_STOP  = 2'b11;
  localparam int UART_DATA_BITS = 8;
  localparam int UART_OVERSAMPLE = 16;
  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_START = ST_START,
    S_DATA  = ST_DATA,
    S_STOP  = ST_STOP
  } uart_state_t;
endpackage

// File: rtl/sync_ff.sv
// sync_ff: N-stage synchronizer for asynchronous pad inputs, resets to all ones
module sync_ff #(
  parameter int STAGES = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk_50m,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [STAGES-1:0][WIDTH-1:0] ff;
  // shift the pad value through the chain; idle-high reset keeps a UART line quiet
  always_ff @(posedge clk_50m or negedge rst)
    if (!rst) ff <= '1;
    else ff <= {ff[STAGES-2:0], d};
  assign q = ff[STAGES-1];
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 receiver on a 16x oversample tick with ready/clear handshake
module uart_receiver
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk_50m,
  input  logic                      rst,
  input  logic                      rx,
  input  logic                      clken,
  input  logic                      rdy_clr,
  output logic [UART_DATA_BITS-1:0] dout,
  output logic                      rdy,
  output logic                      frame_err,
  output logic                      overrun,
  output logic                      rx_busy
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] CNT_MID = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(UART_DATA_BITS - 1);
  uart_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic wait_q, wait_d;
  logic rxs, done, ferr_set;
  sync_ff #(.STAGES(SYNC_STAGES), .WIDTH(1)) u_sync (
    .clk_50m(clk_50m),
    .rst(rst),
    .d(rx),
    .q(rxs)
  );
  // frame sequencing registers
  always_ff @(posedge clk_50m or negedge rst)
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      shift_q <= '0;
      wait_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      shift_q <= shift_d;
      wait_q <= wait_d;
    end
  // next-state: advance only on oversample ticks; wait_q blocks a restart on a line stuck low after a bad stop bit
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    shift_d = shift_q;
    wait_d = wait_q;
    done = 1'b0;
    ferr_set = 1'b0;
    if (clken)
      case (state_q)
        S_IDLE:
          if (wait_q) wait_d = ~rxs;
          else if (!rxs) begin
            state_d = S_START;
            cnt_d = '0;
          end
        S_START:
          if (cnt_q == CNT_MID) begin
            cnt_d = '0;
            idx_d = '0;
            state_d = rxs ? S_IDLE : S_DATA;
          end else cnt_d = cnt_q + CW'(1);
        S_DATA:
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            shift_d = {rxs, shift_q[UART_DATA_BITS-1:1]};
            idx_d = idx_q + IW'(1);
            state_d = (idx_q == IDX_LAST) ? S_STOP : S_DATA;
          end else cnt_d = cnt_q + CW'(1);
        S_STOP:
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            state_d = S_IDLE;
            done = rxs;
            ferr_set = ~rxs;
            wait_d = ~rxs;
          end else cnt_d = cnt_q + CW'(1);
        default: state_d = S_IDLE;
      endcase
  end
  // host handshake: a completing byte beats a same-cycle clear; rdy_clr acknowledges both flags
  always_ff @(posedge clk_50m or negedge rst)
    if (!rst) begin
      dout <= '0;
      rdy <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (done) dout <= shift_q;
      rdy <= done | (rdy & ~rdy_clr);
      overrun <= (done & rdy & ~rdy_clr) | (overrun & ~rdy_clr);
      frame_err <= ferr_set | (frame_err & ~rdy_clr);
    end
  assign rx_busy = (state_q != S_IDLE);
endmodule
